frame_scheduler: RTL



---
 rtl/frame_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: clears the back buffer, issues triangle indices to the
// rasterizer, waits for it to go idle, then swaps buffers on the next frame tick.
module frame_scheduler #(
   parameter int unsigned FB_PIXELS = 57600,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned TRI_W     = 8
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              new_frame_in,
   input  logic [TRI_W-1:0]  num_tri_in,
   output logic              clear_we_out,
   output logic [ADDR_W-1:0] clear_addr_out,
   output logic              tri_valid_out,
   output logic [TRI_W-1:0]  tri_idx_out,
   input  logic              tri_ready_in,
   input  logic              raster_busy_in,
   output logic              buf_sel_out,
   output logic              frame_done_out,
   output logic [7:0]        overrun_cnt_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_DRAIN,
      S_WAIT_SWAP
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

   state_t              r_state;
   logic [TRI_W-1:0]    r_num_tri;
   logic                r_clear_we;
   logic [ADDR_W-1:0]   r_clear_addr;
   logic                r_tri_valid;
   logic [TRI_W-1:0]    r_tri_idx;
   logic                r_drain_first;
   logic                r_buf_sel;
   logic                r_frame_done;
   logic [7:0]          r_overrun_cnt;

   logic                w_overrun;
   logic                w_tri_last;

   // A tick is an overrun whenever a render is still in flight, including the
   // cycle in which DRAIN hands over to WAIT_SWAP.
   assign w_overrun  = new_frame_in &&
                       (r_state == S_CLEAR || r_state == S_ISSUE || r_state == S_DRAIN);
   assign w_tri_last = (r_tri_idx == r_num_tri - TRI_W'(1));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state       <= S_IDLE;
         r_num_tri     <= '0;
         r_clear_we    <= 1'b0;
         r_clear_addr  <= '0;
         r_tri_valid   <= 1'b0;
         r_tri_idx     <= '0;
         r_drain_first <= 1'b0;
         r_buf_sel     <= 1'b0;
         r_frame_done  <= 1'b0;
         r_overrun_cnt <= '0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_overrun && r_overrun_cnt != 8'hFF) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
         end

         case (r_state)
            S_IDLE: begin
               if (new_frame_in) begin
                  r_num_tri    <= num_tri_in;
                  r_clear_we   <= 1'b1;
                  r_clear_addr <= '0;
                  r_state      <= S_CLEAR;
               end
            end

            S_CLEAR: begin
               if (r_clear_addr == LAST_ADDR) begin
                  r_clear_we <= 1'b0;
                  if (r_num_tri == '0) begin
                     r_drain_first <= 1'b1;
                     r_state       <= S_DRAIN;
                  end else begin
                     r_tri_valid <= 1'b1;
                     r_tri_idx   <= '0;
                     r_state     <= S_ISSUE;
                  end
               end else begin
                  r_clear_addr <= r_clear_addr + ADDR_W'(1);
               end
            end

            S_ISSUE: begin
               if (tri_ready_in) begin
                  if (w_tri_last) begin
                     r_tri_valid   <= 1'b0;
                     r_drain_first <= 1'b1;
                     r_state       <= S_DRAIN;
                  end else begin
                     r_tri_idx <= r_tri_idx + TRI_W'(1);
                  end
               end
            end

            S_DRAIN: begin
               // Busy is ignored for one cycle to cover the rasterizer's busy latency.
               if (r_drain_first) begin
                  r_drain_first <= 1'b0;
               end else if (!raster_busy_in) begin
                  r_state <= S_WAIT_SWAP;
               end
            end

            S_WAIT_SWAP: begin
               if (new_frame_in) begin
                  r_buf_sel    <= ~r_buf_sel;
                  r_frame_done <= 1'b1;
                  r_num_tri    <= num_tri_in;
                  r_clear_we   <= 1'b1;
                  r_clear_addr <= '0;
                  r_state      <= S_CLEAR;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign clear_we_out    = r_clear_we;
   assign clear_addr_out  = r_clear_addr;
   assign tri_valid_out   = r_tri_valid;
   assign tri_idx_out     = r_tri_idx;
   assign buf_sel_out     = r_buf_sel;
   assign frame_done_out  = r_frame_done;
   assign overrun_cnt_out = r_overrun_cnt;

endmodule
